// File: rtl/serv_ifetch.sv
// Instruction fetch stage: issues one bus read per accepted request, holds the
// returned word for the decoder, and flags misaligned requests and bus timeouts.
module serv_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_req,
  input  logic [31:0] i_pc,
  output logic        o_busy,
  output logic [31:0] o_ibus_adr,
  output logic        o_ibus_cyc,
  input  logic [31:0] i_ibus_rdt,
  input  logic        i_ibus_ack,
  output logic        o_wb_en,
  output logic [31:0] o_wb_rdt,
  output logic        o_misalign,
  output logic        o_ibus_err
);

  typedef enum logic [1:0] {IDLE, BUS, DELIVER} state_t;

  state_t state;
  state_t state_next;

  logic accept;
  logic reject;
  logic bus_ack;
  logic timeout_hit;

  assign accept  = (state == IDLE) && i_fetch_req && (i_pc[1:0] == 2'b00);
  assign reject  = (state == IDLE) && i_fetch_req && (i_pc[1:0] != 2'b00);
  assign bus_ack = (state == BUS) && i_ibus_ack;

  generate
    if (TIMEOUT > 0) begin : g_timeout
      localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
      logic [15:0] tmo_cnt;

      // Counts BUS cycles without ack; restarts on every new bus cycle.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          tmo_cnt <= 16'd0;
        end else if (accept || timeout_hit) begin
          tmo_cnt <= 16'd0;
        end else if ((state == BUS) && !i_ibus_ack) begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end
      end

      // Ack in the final allowed cycle wins over the timeout.
      assign timeout_hit = (state == BUS) && !i_ibus_ack && (tmo_cnt == TMO_LAST);
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    o_busy     = 1'b1;
    o_ibus_cyc = 1'b0;
    o_wb_en    = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (accept) begin
          state_next = BUS;
        end
      end
      BUS: begin
        o_ibus_cyc = 1'b1;
        if (i_ibus_ack) begin
          state_next = DELIVER;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      DELIVER: begin
        o_wb_en    = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ibus_adr <= {RESET_PC[31:2], 2'b00};
      o_wb_rdt   <= 32'd0;
      o_misalign <= 1'b0;
      o_ibus_err <= 1'b0;
    end else begin
      o_misalign <= reject;
      o_ibus_err <= timeout_hit;
      if (accept) begin
        o_ibus_adr <= {i_pc[31:2], 2'b00};
      end
      // Only acks that answer our own bus cycle update the held word.
      if (bus_ack) begin
        o_wb_rdt <= i_ibus_rdt;
      end
    end
  end

endmodule

// File: tb/tb_serv_ifetch.sv
// Bench for serv_ifetch: two instances (no timeout, TIMEOUT=4) driven by
// directed and random fetches, checked against a transaction-level model.
module tb_serv_ifetch;

  localparam logic [31:0] RST_A = 32'h0000_0200;
  localparam logic [31:0] RST_B = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_a, req_b, ack_a, ack_b;
  logic [31:0] pc, rdt;

  logic        busy_a, cyc_a, en_a, mis_a, err_a;
  logic [31:0] adr_a, wrdt_a;
  logic        busy_b, cyc_b, en_b, mis_b, err_b;
  logic [31:0] adr_b, wrdt_b;

  logic        sel;
  logic        busy_s, cyc_s, en_s, mis_s, err_s;
  logic [31:0] adr_s, wrdt_s;

  int compared   = 0;
  int mismatched = 0;

  logic [31:0] m_adr [2];
  logic [31:0] m_rdt [2];

  always #5 clk = ~clk;

  serv_ifetch #(.RESET_PC(32'h0000_0203), .TIMEOUT(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_fetch_req(req_a), .i_pc(pc),
    .o_busy(busy_a), .o_ibus_adr(adr_a), .o_ibus_cyc(cyc_a),
    .i_ibus_rdt(rdt), .i_ibus_ack(ack_a), .o_wb_en(en_a), .o_wb_rdt(wrdt_a),
    .o_misalign(mis_a), .o_ibus_err(err_a)
  );

  serv_ifetch #(.RESET_PC(32'h8000_0001), .TIMEOUT(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_fetch_req(req_b), .i_pc(pc),
    .o_busy(busy_b), .o_ibus_adr(adr_b), .o_ibus_cyc(cyc_b),
    .i_ibus_rdt(rdt), .i_ibus_ack(ack_b), .o_wb_en(en_b), .o_wb_rdt(wrdt_b),
    .o_misalign(mis_b), .o_ibus_err(err_b)
  );

  assign busy_s = sel ? busy_b : busy_a;
  assign cyc_s  = sel ? cyc_b  : cyc_a;
  assign en_s   = sel ? en_b   : en_a;
  assign mis_s  = sel ? mis_b  : mis_a;
  assign err_s  = sel ? err_b  : err_a;
  assign adr_s  = sel ? adr_b  : adr_a;
  assign wrdt_s = sel ? wrdt_b : wrdt_a;

  // One fetch attempt on the selected instance. wt = cycles before ack.
  task automatic run_fetch(input int s, input logic [31:0] a, input logic [31:0] d,
                           input int wt, input bit mid_req);
    int ncyc = 0, nen = 0, nerr = 0, nmis = 0, nbusy = 0;
    int exp_cyc, exp_en, exp_err, exp_mis;
    bit aligned = (a[1:0] == 2'b00);
    bit timed_out = (s == 1) && (wt >= 4);
    logic [31:0] adr_word = {a[31:2], 2'b00};
    sel = s[0];
    @(negedge clk);
    pc = a;
    req_a = (s == 0);
    req_b = (s == 1);
    for (int i = 1; i <= wt + 7; i++) begin
      @(negedge clk);
      ncyc  += int'(cyc_s);
      nen   += int'(en_s);
      nerr  += int'(err_s);
      nmis  += int'(mis_s);
      nbusy += int'(busy_s);
      if (cyc_s) begin
        compared++;
        if (adr_s !== adr_word) begin
          mismatched++;
          $display("FAIL adr_stable: got %h want %h", adr_s, adr_word);
        end
      end
      if (en_s) begin
        compared++;
        if (wrdt_s !== d) begin
          mismatched++;
          $display("FAIL wb_rdt_at_en: got %h want %h", wrdt_s, d);
        end
      end
      req_a = (s == 0) && mid_req && aligned && (i == 2);
      req_b = (s == 1) && mid_req && aligned && (i == 2);
      ack_a = (s == 0) && (i == wt + 1);
      ack_b = (s == 1) && (i == wt + 1);
      rdt   = (i == wt + 1) ? d : $urandom;
      pc    = $urandom;
    end
    ack_a = 1'b0;
    ack_b = 1'b0;

    exp_cyc = 0; exp_en = 0; exp_err = 0; exp_mis = 0;
    if (!aligned) begin
      exp_mis = 1;
    end else if (timed_out) begin
      exp_cyc = 4;
      exp_err = 1;
      m_adr[s] = adr_word;
    end else begin
      exp_cyc = wt + 1;
      exp_en  = 1;
      m_adr[s] = adr_word;
      m_rdt[s] = d;
    end

    compared += 7;
    if (ncyc !== exp_cyc) begin
      mismatched++; $display("FAIL cyc_cycles: got %0d want %0d", ncyc, exp_cyc);
    end
    if (nen !== exp_en) begin
      mismatched++; $display("FAIL wb_en_pulses: got %0d want %0d", nen, exp_en);
    end
    if (nerr !== exp_err) begin
      mismatched++; $display("FAIL err_pulses: got %0d want %0d", nerr, exp_err);
    end
    if (nmis !== exp_mis) begin
      mismatched++; $display("FAIL misalign_pulses: got %0d want %0d", nmis, exp_mis);
    end
    if (nbusy !== exp_cyc + exp_en) begin
      mismatched++; $display("FAIL busy_cycles: got %0d want %0d", nbusy, exp_cyc + exp_en);
    end
    if (adr_s !== m_adr[s]) begin
      mismatched++; $display("FAIL adr_final: got %h want %h", adr_s, m_adr[s]);
    end
    if (wrdt_s !== m_rdt[s]) begin
      mismatched++; $display("FAIL rdt_final: got %h want %h", wrdt_s, m_rdt[s]);
    end
    $display("txn dut%0d pc=%h wait=%0d midreq=%0d cyc=%0d en=%0d err=%0d mis=%0d rdt=%h",
             s, a, wt, mid_req, ncyc, nen, nerr, nmis, wrdt_s);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_a = 0; req_b = 0; ack_a = 0; ack_b = 0; pc = 0; rdt = 0; sel = 0;
    #1;
    compared += 6;
    if (adr_a !== RST_A || adr_b !== RST_B) begin
      mismatched++; $display("FAIL reset_adr: got %h/%h want %h/%h", adr_a, adr_b, RST_A, RST_B);
    end
    if (cyc_a !== 1'b0 || cyc_b !== 1'b0) begin
      mismatched++; $display("FAIL reset_cyc: got %b/%b want 0/0", cyc_a, cyc_b);
    end
    if (en_a !== 1'b0 || en_b !== 1'b0) begin
      mismatched++; $display("FAIL reset_en: got %b/%b want 0/0", en_a, en_b);
    end
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      mismatched++; $display("FAIL reset_busy: got %b/%b want 0/0", busy_a, busy_b);
    end
    if ({mis_a, mis_b, err_a, err_b} !== 4'b0000) begin
      mismatched++; $display("FAIL reset_flags: got %b want 0000", {mis_a, mis_b, err_a, err_b});
    end
    if (wrdt_a !== 32'd0 || wrdt_b !== 32'd0) begin
      mismatched++; $display("FAIL reset_rdt: got %h/%h want 0", wrdt_a, wrdt_b);
    end
    m_adr[0] = RST_A; m_adr[1] = RST_B; m_rdt[0] = 0; m_rdt[1] = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    $display("txn reset adr_a=%h adr_b=%h", adr_a, adr_b);
  endtask

  task automatic test_zero_wait();
    run_fetch(0, 32'h0000_0100, 32'h00A0_0093, 0, 1'b0);
  endtask

  task automatic test_wait_states();
    run_fetch(0, 32'h0000_0204, 32'h1234_5678, 5, 1'b1);
  endtask

  task automatic test_misalign();
    run_fetch(0, 32'h0000_0102, 32'hDEAD_BEEF, 1, 1'b0);
  endtask

  task automatic test_timeout();
    run_fetch(1, 32'h0000_0400, 32'hCAFE_0001, 20, 1'b1);
    run_fetch(1, 32'h0000_0408, 32'hCAFE_0002, 3, 1'b0);
  endtask

  task automatic test_unsolicited();
    int nen = 0;
    sel = 0;
    @(negedge clk);
    ack_a = 1'b1; rdt = 32'hFFFF_FFFF;
    repeat (3) begin
      @(negedge clk);
      nen += int'(en_a);
    end
    ack_a = 1'b0;
    compared += 2;
    if (nen !== 0) begin
      mismatched++; $display("FAIL unsolicited_en: got %0d want 0", nen);
    end
    if (wrdt_a !== m_rdt[0]) begin
      mismatched++; $display("FAIL unsolicited_rdt: got %h want %h", wrdt_a, m_rdt[0]);
    end
    $display("txn unsolicited ack rdt=%h en_pulses=%0d", wrdt_a, nen);
  endtask

  task automatic test_back_to_back();
    sel = 0;
    @(negedge clk); pc = 32'h0000_0600; req_a = 1;
    @(negedge clk); req_a = 0; ack_a = 1; rdt = 32'h0000_1111;
    @(negedge clk); ack_a = 0;
    compared++;
    if (en_a !== 1'b1 || wrdt_a !== 32'h0000_1111) begin
      mismatched++; $display("FAIL b2b_first: got en=%b rdt=%h want en=1 rdt=00001111", en_a, wrdt_a);
    end
    @(negedge clk); pc = 32'h0000_0604; req_a = 1;
    compared++;
    if (busy_a !== 1'b0) begin
      mismatched++; $display("FAIL b2b_idle: got busy=%b want 0", busy_a);
    end
    @(negedge clk); req_a = 0; ack_a = 1; rdt = 32'h0000_2222;
    compared++;
    if (cyc_a !== 1'b1 || adr_a !== 32'h0000_0604) begin
      mismatched++; $display("FAIL b2b_second_cyc: got cyc=%b adr=%h want cyc=1 adr=00000604", cyc_a, adr_a);
    end
    @(negedge clk); ack_a = 0;
    compared++;
    if (en_a !== 1'b1 || wrdt_a !== 32'h0000_2222) begin
      mismatched++; $display("FAIL b2b_second: got en=%b rdt=%h want en=1 rdt=00002222", en_a, wrdt_a);
    end
    m_adr[0] = 32'h0000_0604; m_rdt[0] = 32'h0000_2222;
    @(negedge clk);
    $display("txn back_to_back rdt=%h", wrdt_a);
  endtask

  task automatic test_reset_mid_bus();
    int nen = 0;
    sel = 0;
    @(negedge clk); pc = 32'h0000_0340; req_a = 1;
    @(negedge clk); req_a = 0;
    @(negedge clk);
    compared++;
    if (cyc_a !== 1'b1) begin
      mismatched++; $display("FAIL rst_bus_pre: got cyc=%b want 1", cyc_a);
    end
    #2 rst = 1'b1;
    #1;
    compared += 2;
    if (cyc_a !== 1'b0 || busy_a !== 1'b0) begin
      mismatched++; $display("FAIL rst_async_cyc: got cyc=%b busy=%b want 0/0", cyc_a, busy_a);
    end
    if (adr_a !== RST_A || adr_b !== RST_B) begin
      mismatched++; $display("FAIL rst_async_adr: got %h/%h want %h/%h", adr_a, adr_b, RST_A, RST_B);
    end
    @(negedge clk); rst = 1'b0; ack_a = 1; rdt = 32'h5555_AAAA;
    repeat (4) begin
      @(negedge clk);
      nen += int'(en_a);
    end
    ack_a = 1'b0;
    m_adr[0] = RST_A; m_adr[1] = RST_B; m_rdt[0] = 0; m_rdt[1] = 0;
    compared += 2;
    if (nen !== 0) begin
      mismatched++; $display("FAIL rst_late_ack_en: got %0d want 0", nen);
    end
    if (wrdt_a !== 32'd0) begin
      mismatched++; $display("FAIL rst_late_ack_rdt: got %h want 00000000", wrdt_a);
    end
    $display("txn reset_mid_bus adr=%h en_pulses=%0d", adr_a, nen);
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      int s = int'($urandom_range(1, 0));
      logic [31:0] a = $urandom;
      if ($urandom_range(3, 0) != 0) a[1:0] = 2'b00;
      run_fetch(s, a, $urandom, int'($urandom_range(7, 0)), 1'($urandom_range(1, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_misalign();
    test_timeout();
    test_unsolicited();
    test_back_to_back();
    test_reset_mid_bus();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
